// File: rtl/mem_responder_if.sv
// Request/response handshake bundle between the executor and the memory responder.
interface mem_responder_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_rw;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_rdata;
  logic       rsp_err;

  modport master (
    output req_valid, req_rw, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_rw, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: byte RAM plus a small GPIO/counter window,
// serviced after a fixed number of wait states.
//
// state | meaning
// IDLE  | ready for a request; accepts on req_valid
// WAIT  | wait-state countdown; access performed when the counter reaches 0
// RESP  | response held on rsp_* until rsp_ready
module mem_responder #(
  parameter int         DEPTH       = 32,
  parameter int         WAIT_STATES = 1,
  parameter logic [7:0] IO_BASE     = 8'hF0
) (
  input  logic            clk,
  input  logic            reset_n,
  mem_responder_if.slave  bus,
  output logic [7:0]      gpio_out,
  input  logic [7:0]      gpio_in
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0] DEPTH_B = 8'(DEPTH);
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [7:0] IO_GPO  = IO_BASE;
  localparam logic [7:0] IO_GPI  = IO_BASE + 8'd1;
  localparam logic [7:0] IO_CNT  = IO_BASE + 8'd2;

  state_t     state, state_nx;
  logic [3:0] cnt;
  logic       ready_en;
  logic [7:0] addr_q, wdata_q;
  logic       rw_q;
  logic [7:0] ram [DEPTH];
  logic [7:0] gpi_meta, gpi_sync;
  logic [7:0] rsp_cnt;
  logic [7:0] rdata_q;
  logic       err_q;

  logic       accept, do_access;
  logic [7:0] acc_addr, acc_wdata;
  logic       acc_rw;
  logic [7:0] acc_rdata;
  logic       acc_err, wr_ram, wr_gpo;

  always_comb begin
    state_nx      = state;
    accept        = 1'b0;
    do_access     = 1'b0;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        // ready_en keeps req_ready low until the first edge after reset release
        bus.req_ready = ready_en;
        if (ready_en && bus.req_valid) begin
          accept = 1'b1;
          if (WAIT_STATES == 0) begin
            do_access = 1'b1;
            state_nx  = RESP;
          end else begin
            state_nx  = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          do_access = 1'b1;
          state_nx  = RESP;
        end
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // With zero wait states the access happens on the accept edge, before the latches load.
  always_comb begin
    acc_addr  = (state == IDLE) ? bus.req_addr  : addr_q;
    acc_wdata = (state == IDLE) ? bus.req_wdata : wdata_q;
    acc_rw    = (state == IDLE) ? bus.req_rw    : rw_q;
  end

  always_comb begin
    acc_rdata = 8'h00;
    acc_err   = 1'b0;
    wr_ram    = 1'b0;
    wr_gpo    = 1'b0;
    if (acc_addr < DEPTH_B) begin
      if (acc_rw) wr_ram    = 1'b1;
      else        acc_rdata = ram[acc_addr[AW-1:0]];
    end else if (acc_addr == IO_GPO) begin
      if (acc_rw) wr_gpo    = 1'b1;
      else        acc_rdata = gpio_out;
    end else if (acc_addr == IO_GPI) begin
      if (acc_rw) acc_err   = 1'b1;
      else        acc_rdata = gpi_sync;
    end else if (acc_addr == IO_CNT) begin
      if (acc_rw) acc_err   = 1'b1;
      else        acc_rdata = rsp_cnt;
    end else begin
      acc_err = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      ready_en <= 1'b0;
      addr_q   <= 8'h00;
      wdata_q  <= 8'h00;
      rw_q     <= 1'b0;
      gpi_meta <= 8'h00;
      gpi_sync <= 8'h00;
      rsp_cnt  <= 8'h00;
      rdata_q  <= 8'h00;
      err_q    <= 1'b0;
      gpio_out <= 8'h00;
    end else begin
      state    <= state_nx;
      ready_en <= 1'b1;
      gpi_meta <= gpio_in;
      gpi_sync <= gpi_meta;
      if (accept) begin
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        rw_q    <= bus.req_rw;
        cnt     <= WS_LOAD;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (do_access) begin
        rdata_q <= acc_rdata;
        err_q   <= acc_err;
        if (wr_gpo) gpio_out <= acc_wdata;
      end
      if (state == RESP && bus.rsp_ready) rsp_cnt <= rsp_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= 8'h00;
    end else if (do_access && wr_ram) begin
      ram[acc_addr[AW-1:0]] <= acc_wdata;
    end
  end

  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomised scoreboard bench for mem_responder against a behavioural memory-map model.
module tb_mem_responder;
  localparam int         WS    = 1;
  localparam int         DEPTH = 32;
  localparam logic [7:0] IO    = 8'hF0;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] gpio_out;
  logic [7:0] gpio_in;

  mem_responder_if bus ();

  mem_responder #(.DEPTH(DEPTH), .WAIT_STATES(WS), .IO_BASE(IO)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .gpio_out (gpio_out),
    .gpio_in  (gpio_in)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  exp_t       q[$];
  logic [7:0] m_ram [DEPTH];
  logic [7:0] m_gpo, m_gpi, m_cnt;
  bit         hold_ready = 1'b0;
  bit         rand_ready = 1'b0;

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_ram[i] = 8'h00;
    m_gpo = 8'h00;
    m_cnt = 8'h00;
    q.delete();
  endtask

  // Memory map: RAM below DEPTH, then gpio_out / gpio_in / response count at IO..IO+2.
  task automatic model_access(input bit rw, input logic [7:0] a, input logic [7:0] d,
                              output exp_t e);
    e.rdata = 8'h00;
    e.err   = 1'b0;
    if (int'(a) < DEPTH) begin
      if (rw) m_ram[int'(a)] = d;
      else    e.rdata = m_ram[int'(a)];
    end else if (a == IO) begin
      if (rw) m_gpo = d;
      else    e.rdata = m_gpo;
    end else if (a == IO + 8'd1) begin
      if (rw) e.err = 1'b1;
      else    e.rdata = m_gpi;
    end else if (a == IO + 8'd2) begin
      if (rw) e.err = 1'b1;
      else    e.rdata = m_cnt;
    end else begin
      e.err = 1'b1;
    end
  endtask

  // Consumer side: backpressure pattern applied just after each rising edge.
  initial begin
    bus.rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (hold_ready)      bus.rsp_ready = 1'b0;
      else if (rand_ready) bus.rsp_ready = ($urandom_range(0, 2) != 0);
      else                 bus.rsp_ready = 1'b1;
    end
  end

  // Monitor: every completed response handshake is checked against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp actual=rsp_valid required=no_response t=%0t", $time);
        end else begin
          e = q.pop_front();
          chk8("rsp_rdata", bus.rsp_rdata, e.rdata);
          chk8("rsp_err", {7'd0, bus.rsp_err}, {7'd0, e.err});
          chk8("gpio_out", gpio_out, m_gpo);
        end
        m_cnt = m_cnt + 8'd1;
      end
    end
  end

  task automatic issue(input bit rw, input logic [7:0] a, input logic [7:0] d);
    int   tries;
    int   lat;
    exp_t e;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_rw    = rw;
    bus.req_addr  = a;
    bus.req_wdata = d;
    tries = 0;
    while (bus.req_ready !== 1'b1 && tries < 200) begin
      @(negedge clk);
      tries++;
    end
    if (bus.req_ready !== 1'b1) begin
      chk_int("accept_timeout", tries, 0);
      bus.req_valid = 1'b0;
      return;
    end
    model_access(rw, a, d, e);
    q.push_back(e);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_rw    = 1'($urandom);
    bus.req_addr  = 8'($urandom);
    bus.req_wdata = 8'($urandom);
    lat = 1;
    while (bus.rsp_valid !== 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk_int("rsp_latency", lat, WS + 1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!(bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk_int("handshake_timeout", n, 0);
  endtask

  task automatic xact(input bit rw, input logic [7:0] a, input logic [7:0] d);
    issue(rw, a, d);
    wait_done();
  endtask

  task automatic set_gpi(input logic [7:0] v);
    gpio_in = v;
    m_gpi   = v;
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk8({tag, "_req_ready"}, {7'd0, bus.req_ready}, 8'h00);
    chk8({tag, "_rsp_valid"}, {7'd0, bus.rsp_valid}, 8'h00);
    chk8({tag, "_rsp_rdata"}, bus.rsp_rdata, 8'h00);
    chk8({tag, "_rsp_err"}, {7'd0, bus.rsp_err}, 8'h00);
    chk8({tag, "_gpio_out"}, gpio_out, 8'h00);
  endtask

  function automatic logic [7:0] rand_addr();
    logic [7:0] a;
    case ($urandom_range(0, 4))
      0, 1:    a = 8'($urandom_range(0, DEPTH - 1));
      2:       a = IO + 8'($urandom_range(0, 3));
      3:       a = 8'($urandom_range(DEPTH, 255));
      default: a = ($urandom_range(0, 1) != 0) ? 8'(DEPTH - 1) : 8'(DEPTH);
    endcase
    return a;
  endfunction

  initial begin
    exp_t e;
    reset_n       = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_rw    = 1'b0;
    bus.req_addr  = 8'h00;
    bus.req_wdata = 8'h00;
    gpio_in       = 8'h00;
    m_gpi         = 8'h00;
    model_reset();
    #1;
    chk_reset_outputs("in_reset");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk8("ready_before_edge", {7'd0, bus.req_ready}, 8'h00);
    @(negedge clk);
    chk8("ready_after_edge", {7'd0, bus.req_ready}, 8'h01);

    xact(1'b0, 8'h05, 8'h00);
    xact(1'b1, 8'h1F, 8'hA5);
    xact(1'b0, 8'h1F, 8'h00);
    xact(1'b0, 8'h20, 8'h00);
    xact(1'b1, 8'hF0, 8'h3C);
    chk8("gpio_after_write", gpio_out, 8'h3C);
    set_gpi(8'h81);
    xact(1'b0, 8'hF1, 8'h00);
    xact(1'b1, 8'hF1, 8'h55);
    chk8("gpio_after_ro_write", gpio_out, 8'h3C);
    xact(1'b0, 8'hF1, 8'h00);

    // Backpressure: response must hold while another request waits to be accepted.
    hold_ready = 1'b1;
    issue(1'b0, 8'h1F, 8'h00);
    e = q[0];
    bus.req_valid = 1'b1;
    bus.req_rw    = 1'b0;
    bus.req_addr  = 8'hF0;
    bus.req_wdata = 8'h00;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk8("bp_rsp_valid", {7'd0, bus.rsp_valid}, 8'h01);
      chk8("bp_rsp_rdata", bus.rsp_rdata, e.rdata);
      chk8("bp_rsp_err", {7'd0, bus.rsp_err}, {7'd0, e.err});
      chk8("bp_req_ready", {7'd0, bus.req_ready}, 8'h00);
    end
    bus.req_valid = 1'b0;
    hold_ready    = 1'b0;
    wait_done();
    xact(1'b0, 8'hF0, 8'h00);

    // Reset in the middle of a write's wait state drops it entirely.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_rw    = 1'b1;
    bus.req_addr  = 8'h02;
    bus.req_wdata = 8'h77;
    for (int i = 0; i < 20 && bus.req_ready !== 1'b1; i++) @(negedge clk);
    chk8("rst_wr_accept", {7'd0, bus.req_ready}, 8'h01);
    @(negedge clk);
    bus.req_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("mid_reset");
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk8("no_rsp_after_reset", {7'd0, bus.rsp_valid}, 8'h00);
    end
    xact(1'b0, 8'h02, 8'h00);

    // Fill out 256 handshakes since reset so the response counter wraps.
    for (int i = 0; i < 255; i++) begin
      if (i % 2 == 0) xact(1'b1, 8'($urandom_range(0, DEPTH - 1)), 8'($urandom));
      else            xact(1'b0, 8'($urandom_range(0, DEPTH - 1)), 8'h00);
    end
    xact(1'b0, 8'hF2, 8'h00);
    xact(1'b0, 8'hF2, 8'h00);

    rand_ready = 1'b1;
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 9) == 0) set_gpi(8'($urandom));
      xact(1'($urandom), rand_addr(), 8'($urandom));
    end
    rand_ready = 1'b0;

    repeat (5) @(negedge clk);
    chk_int("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
